// File: rtl/map_table_pkg.sv
// Shared rename definitions: tag width, register space and map entry.
// Reused by the ROB and reservation stations.
package map_table_pkg;

  localparam int NUM_ARCH_REGS = 32;
  localparam int TAG_BITS      = 5;
  localparam int REG_BITS      = 5;

  typedef logic [TAG_BITS-1:0] tag_t;
  typedef logic [REG_BITS-1:0] areg_t;

  localparam areg_t ZERO_REG = 5'd31;

  typedef struct packed {
    logic valid;
    logic ready;
    tag_t tag;
  } map_entry_t;

endpackage

// File: rtl/map_lookup.sv
// One source-operand lookup: table entry, same-cycle CDB bypass,
// and optional forward from the older dispatch slot.
module map_lookup
  import map_table_pkg::*;
(
  input  areg_t      i_src,
  input  map_entry_t i_entry,
  input  logic       i_cdb_en1,
  input  tag_t       i_cdb_tag1,
  input  logic       i_cdb_en2,
  input  tag_t       i_cdb_tag2,
  input  logic       i_fwd_en,
  input  areg_t      i_fwd_dest,
  input  tag_t       i_fwd_tag,
  output logic       o_mapped,
  output tag_t       o_tag,
  output logic       o_ready
);

  logic w_fwd;
  logic w_hit;
  logic w_cdb;

  assign w_fwd = i_fwd_en && (i_src == i_fwd_dest);
  assign w_hit = i_entry.valid && (i_src != ZERO_REG);
  assign w_cdb = (i_cdb_en1 && (i_cdb_tag1 == i_entry.tag))
              || (i_cdb_en2 && (i_cdb_tag2 == i_entry.tag));

  always_comb begin
    o_mapped = 1'b0;
    o_tag    = '0;
    o_ready  = 1'b0;
    if (w_fwd) begin
      // producer is dispatching alongside us: cannot be ready yet
      o_mapped = 1'b1;
      o_tag    = i_fwd_tag;
    end else if (w_hit) begin
      o_mapped = 1'b1;
      o_tag    = i_entry.tag;
      o_ready  = i_entry.ready || w_cdb;
    end
  end

endmodule

// File: rtl/map_table.sv
// Register alias table for the two-wide OoO core.
// Maps arch registers to in-flight ROB tags plus a ready bit.
module map_table
  import map_table_pkg::*;
(
  input  logic  clock,
  input  logic  reset,
  input  logic  flush,
  input  logic  disp_en1,
  input  logic  disp_en2,
  input  areg_t disp_dest1,
  input  areg_t disp_dest2,
  input  tag_t  disp_tag1,
  input  tag_t  disp_tag2,
  input  areg_t src1a,
  input  areg_t src1b,
  input  areg_t src2a,
  input  areg_t src2b,
  output logic  src1a_mapped,
  output logic  src1b_mapped,
  output logic  src2a_mapped,
  output logic  src2b_mapped,
  output tag_t  src1a_tag,
  output tag_t  src1b_tag,
  output tag_t  src2a_tag,
  output tag_t  src2b_tag,
  output logic  src1a_ready,
  output logic  src1b_ready,
  output logic  src2a_ready,
  output logic  src2b_ready,
  input  logic  cdb_en1,
  input  logic  cdb_en2,
  input  tag_t  cdb_tag1,
  input  tag_t  cdb_tag2,
  input  logic  ret_en,
  input  areg_t ret_reg,
  input  tag_t  ret_tag
);

  map_entry_t r_map  [NUM_ARCH_REGS];
  map_entry_t w_next [NUM_ARCH_REGS];
  logic       w_fwd_en;

  assign w_fwd_en = disp_en1 && (disp_dest1 != ZERO_REG);

  always_comb begin
    w_next = r_map;
    for (int r = 0; r < NUM_ARCH_REGS; r++) begin
      if (r_map[r].valid
          && ((cdb_en1 && (r_map[r].tag == cdb_tag1))
           || (cdb_en2 && (r_map[r].tag == cdb_tag2))))
        w_next[r].ready = 1'b1;
    end
    // a tag mismatch means a younger producer owns the register now
    if (ret_en && (ret_reg != ZERO_REG) && r_map[ret_reg].valid
        && (r_map[ret_reg].tag == ret_tag)) begin
      w_next[ret_reg].valid = 1'b0;
      w_next[ret_reg].ready = 1'b0;
    end
    if (w_fwd_en)
      w_next[disp_dest1] = '{valid: 1'b1, ready: 1'b0, tag: disp_tag1};
    if (disp_en2 && (disp_dest2 != ZERO_REG))
      w_next[disp_dest2] = '{valid: 1'b1, ready: 1'b0, tag: disp_tag2};
    if (flush) begin
      for (int r = 0; r < NUM_ARCH_REGS; r++)
        w_next[r] = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NUM_ARCH_REGS; r++)
        r_map[r] <= '0;
    end else begin
      r_map <= w_next;
    end
  end

  map_lookup u_lk1a (
    .i_src      (src1a),
    .i_entry    (r_map[src1a]),
    .i_cdb_en1  (cdb_en1),
    .i_cdb_tag1 (cdb_tag1),
    .i_cdb_en2  (cdb_en2),
    .i_cdb_tag2 (cdb_tag2),
    .i_fwd_en   (1'b0),
    .i_fwd_dest (ZERO_REG),
    .i_fwd_tag  ('0),
    .o_mapped   (src1a_mapped),
    .o_tag      (src1a_tag),
    .o_ready    (src1a_ready)
  );

  map_lookup u_lk1b (
    .i_src      (src1b),
    .i_entry    (r_map[src1b]),
    .i_cdb_en1  (cdb_en1),
    .i_cdb_tag1 (cdb_tag1),
    .i_cdb_en2  (cdb_en2),
    .i_cdb_tag2 (cdb_tag2),
    .i_fwd_en   (1'b0),
    .i_fwd_dest (ZERO_REG),
    .i_fwd_tag  ('0),
    .o_mapped   (src1b_mapped),
    .o_tag      (src1b_tag),
    .o_ready    (src1b_ready)
  );

  map_lookup u_lk2a (
    .i_src      (src2a),
    .i_entry    (r_map[src2a]),
    .i_cdb_en1  (cdb_en1),
    .i_cdb_tag1 (cdb_tag1),
    .i_cdb_en2  (cdb_en2),
    .i_cdb_tag2 (cdb_tag2),
    .i_fwd_en   (w_fwd_en),
    .i_fwd_dest (disp_dest1),
    .i_fwd_tag  (disp_tag1),
    .o_mapped   (src2a_mapped),
    .o_tag      (src2a_tag),
    .o_ready    (src2a_ready)
  );

  map_lookup u_lk2b (
    .i_src      (src2b),
    .i_entry    (r_map[src2b]),
    .i_cdb_en1  (cdb_en1),
    .i_cdb_tag1 (cdb_tag1),
    .i_cdb_en2  (cdb_en2),
    .i_cdb_tag2 (cdb_tag2),
    .i_fwd_en   (w_fwd_en),
    .i_fwd_dest (disp_dest1),
    .i_fwd_tag  (disp_tag1),
    .o_mapped   (src2b_mapped),
    .o_tag      (src2b_tag),
    .o_ready    (src2b_ready)
  );

endmodule

// File: tb/tb_map_table.sv
// Bench for map_table: directed scenarios plus random traffic
// against an array-based rename model.
module tb_map_table;
  import map_table_pkg::*;

  logic clock = 1'b0;
  logic reset, flush;
  logic disp_en1, disp_en2;
  areg_t disp_dest1, disp_dest2;
  tag_t disp_tag1, disp_tag2;
  areg_t src1a, src1b, src2a, src2b;
  logic src1a_mapped, src1b_mapped, src2a_mapped, src2b_mapped;
  tag_t src1a_tag, src1b_tag, src2a_tag, src2b_tag;
  logic src1a_ready, src1b_ready, src2a_ready, src2b_ready;
  logic cdb_en1, cdb_en2;
  tag_t cdb_tag1, cdb_tag2;
  logic ret_en;
  areg_t ret_reg;
  tag_t ret_tag;

  int checks = 0;
  int errors = 0;

  bit       m_valid [32];
  bit       m_ready [32];
  bit [4:0] m_tag   [32];

  always #5 clock = ~clock;

  map_table dut (
    .clock(clock), .reset(reset), .flush(flush),
    .disp_en1(disp_en1), .disp_en2(disp_en2),
    .disp_dest1(disp_dest1), .disp_dest2(disp_dest2),
    .disp_tag1(disp_tag1), .disp_tag2(disp_tag2),
    .src1a(src1a), .src1b(src1b), .src2a(src2a), .src2b(src2b),
    .src1a_mapped(src1a_mapped), .src1b_mapped(src1b_mapped),
    .src2a_mapped(src2a_mapped), .src2b_mapped(src2b_mapped),
    .src1a_tag(src1a_tag), .src1b_tag(src1b_tag),
    .src2a_tag(src2a_tag), .src2b_tag(src2b_tag),
    .src1a_ready(src1a_ready), .src1b_ready(src1b_ready),
    .src2a_ready(src2a_ready), .src2b_ready(src2b_ready),
    .cdb_en1(cdb_en1), .cdb_en2(cdb_en2),
    .cdb_tag1(cdb_tag1), .cdb_tag2(cdb_tag2),
    .ret_en(ret_en), .ret_reg(ret_reg), .ret_tag(ret_tag)
  );

  function automatic logic [6:0] exp_op(input bit [4:0] s, input bit slot2);
    bit rd;
    if (slot2 && disp_en1 && disp_dest1 != 5'd31 && s == disp_dest1)
      return {1'b1, disp_tag1, 1'b0};
    if (s == 5'd31 || !m_valid[s]) return 7'd0;
    rd = m_ready[s] || (cdb_en1 && cdb_tag1 == m_tag[s])
                    || (cdb_en2 && cdb_tag2 == m_tag[s]);
    return {1'b1, m_tag[s], rd};
  endfunction

  function automatic logic [27:0] exp_all();
    return {exp_op(src1a, 0), exp_op(src1b, 0),
            exp_op(src2a, 1), exp_op(src2b, 1)};
  endfunction

  function automatic logic [27:0] obs_all();
    return {src1a_mapped, src1a_tag, src1a_ready,
            src1b_mapped, src1b_tag, src1b_ready,
            src2a_mapped, src2a_tag, src2a_ready,
            src2b_mapped, src2b_tag, src2b_ready};
  endfunction

  function automatic void model_clear();
    for (int r = 0; r < 32; r++) begin
      m_valid[r] = 0; m_ready[r] = 0; m_tag[r] = 0;
    end
  endfunction

  // Apply one clock of the rename rules to the model.
  function automatic void model_step();
    bit       ov [32];
    bit [4:0] ot [32];
    if (!reset || flush) begin
      model_clear();
      return;
    end
    ov = m_valid; ot = m_tag;
    for (int r = 0; r < 32; r++)
      if (ov[r] && ((cdb_en1 && ot[r] == cdb_tag1) ||
                    (cdb_en2 && ot[r] == cdb_tag2)))
        m_ready[r] = 1;
    if (ret_en && ret_reg != 5'd31 && ov[ret_reg] && ot[ret_reg] == ret_tag) begin
      m_valid[ret_reg] = 0; m_ready[ret_reg] = 0;
    end
    if (disp_en1 && disp_dest1 != 5'd31) begin
      m_valid[disp_dest1] = 1; m_ready[disp_dest1] = 0;
      m_tag[disp_dest1] = disp_tag1;
    end
    if (disp_en2 && disp_dest2 != 5'd31) begin
      m_valid[disp_dest2] = 1; m_ready[disp_dest2] = 0;
      m_tag[disp_dest2] = disp_tag2;
    end
  endfunction

  task automatic idle();
    flush = 0; disp_en1 = 0; disp_en2 = 0;
    disp_dest1 = 0; disp_dest2 = 0; disp_tag1 = 0; disp_tag2 = 0;
    src1a = 0; src1b = 0; src2a = 0; src2b = 0;
    cdb_en1 = 0; cdb_en2 = 0; cdb_tag1 = 0; cdb_tag2 = 0;
    ret_en = 0; ret_reg = 0; ret_tag = 0;
  endtask

  task automatic next();
    model_step();
    @(negedge clock);
    idle();
  endtask

  task automatic test_reset();
    reset = 0; idle(); model_clear();
    src1a = 3; src1b = 5; src2a = 8; src2b = 31;
    @(negedge clock); #1;
    checks++;
    if (obs_all() !== 28'd0) begin
      errors++; $display("FAIL reset_outputs got %h want 0", obs_all());
    end
    @(negedge clock);
    reset = 1; idle();
  endtask

  task automatic test_dispatch_cdb();
    disp_en1 = 1; disp_dest1 = 5; disp_tag1 = 7; src1a = 5;
    #1 checks++;
    if (src1a_mapped !== 1'b0) begin
      errors++; $display("FAIL disp_before got %b want 0", src1a_mapped);
    end
    next();
    src1a = 5; #1 checks++;
    if ({src1a_mapped, src1a_tag, src1a_ready} !== {1'b1, 5'd7, 1'b0}) begin
      errors++; $display("FAIL disp_map got %h want %h",
        {src1a_mapped, src1a_tag, src1a_ready}, {1'b1, 5'd7, 1'b0});
    end
    cdb_en1 = 1; cdb_tag1 = 7; #1 checks++;
    if (src1a_ready !== 1'b1 || obs_all() !== exp_all()) begin
      errors++; $display("FAIL cdb_bypass got %h want %h", obs_all(), exp_all());
    end
    next();
    src2b = 5; #1 checks++;
    if ({src2b_mapped, src2b_tag, src2b_ready} !== {1'b1, 5'd7, 1'b1}) begin
      errors++; $display("FAIL cdb_state got %h want %h",
        {src2b_mapped, src2b_tag, src2b_ready}, {1'b1, 5'd7, 1'b1});
    end
    next();
  endtask

  task automatic test_forward();
    disp_en1 = 1; disp_dest1 = 4; disp_tag1 = 9;
    src2a = 4; src1a = 4; #1 checks++;
    if ({src2a_mapped, src2a_tag, src2a_ready} !== {1'b1, 5'd9, 1'b0}
        || src1a_mapped !== 1'b0) begin
      errors++; $display("FAIL fwd_slot2 got %h want %h", obs_all(), exp_all());
    end
    next();
    disp_en1 = 1; disp_dest1 = 6; disp_tag1 = 10;
    disp_en2 = 1; disp_dest2 = 6; disp_tag2 = 11;
    next();
    src1a = 6; src1b = 4; #1 checks++;
    if ({src1a_mapped, src1a_tag, src1a_ready, src1b_mapped, src1b_tag, src1b_ready}
        !== {1'b1, 5'd11, 1'b0, 1'b1, 5'd9, 1'b0}) begin
      errors++; $display("FAIL same_dest got %h want %h", obs_all(), exp_all());
    end
    next();
  endtask

  task automatic test_retire();
    disp_en1 = 1; disp_dest1 = 8; disp_tag1 = 3;
    next();
    disp_en1 = 1; disp_dest1 = 8; disp_tag1 = 12;
    next();
    ret_en = 1; ret_reg = 8; ret_tag = 3;
    next();
    src1a = 8; #1 checks++;
    if ({src1a_mapped, src1a_tag, src1a_ready} !== {1'b1, 5'd12, 1'b0}) begin
      errors++; $display("FAIL stale_retire got %h want %h",
        {src1a_mapped, src1a_tag, src1a_ready}, {1'b1, 5'd12, 1'b0});
    end
    ret_en = 1; ret_reg = 8; ret_tag = 12;
    next();
    src1a = 8; #1 checks++;
    if (src1a_mapped !== 1'b0 || src1a_tag !== 5'd0) begin
      errors++; $display("FAIL retire got %b/%h want 0/0", src1a_mapped, src1a_tag);
    end
    next();
  endtask

  task automatic test_flush();
    flush = 1; disp_en1 = 1; disp_dest1 = 2; disp_tag1 = 4;
    cdb_en1 = 1; cdb_tag1 = 3;
    next();
    for (int r = 0; r < 32; r += 4) begin
      src1a = 5'(r); src1b = 5'(r + 1); src2a = 5'(r + 2); src2b = 5'(r + 3);
      #1 checks++;
      if (obs_all() !== 28'd0) begin
        errors++; $display("FAIL flush r%0d got %h want 0", r, obs_all());
      end
    end
    next();
  endtask

  task automatic test_zero_dual_cdb();
    disp_en1 = 1; disp_dest1 = 31; disp_tag1 = 5;
    disp_en2 = 1; disp_dest2 = 1; disp_tag2 = 1;
    src2a = 31; #1 checks++;
    if (src2a_mapped !== 1'b0) begin
      errors++; $display("FAIL r31_fwd got %b want 0", src2a_mapped);
    end
    next();
    disp_en1 = 1; disp_dest1 = 2; disp_tag1 = 2;
    src1a = 31; #1 checks++;
    if ({src1a_mapped, src1a_tag} !== 6'd0) begin
      errors++; $display("FAIL r31_map got %h want 0", {src1a_mapped, src1a_tag});
    end
    next();
    cdb_en1 = 1; cdb_tag1 = 1; cdb_en2 = 1; cdb_tag2 = 2;
    next();
    src1a = 1; src1b = 2; #1 checks++;
    if ({src1a_mapped, src1a_tag, src1a_ready, src1b_mapped, src1b_tag, src1b_ready}
        !== {1'b1, 5'd1, 1'b1, 1'b1, 5'd2, 1'b1}) begin
      errors++; $display("FAIL dual_cdb got %h want %h", obs_all(), exp_all());
    end
    next();
  endtask

  task automatic test_reset_midrun();
    disp_en1 = 1; disp_dest1 = 3; disp_tag1 = 13;
    next();
    src1a = 3; src2b = 3; #1 checks++;
    if ({src1a_mapped, src1a_tag} !== {1'b1, 5'd13}) begin
      errors++; $display("FAIL pre_reset got %h want %h",
        {src1a_mapped, src1a_tag}, {1'b1, 5'd13});
    end
    reset = 0; model_clear(); #1 checks++;
    if (obs_all() !== 28'd0) begin
      errors++; $display("FAIL async_reset got %h want 0", obs_all());
    end
    next();
    reset = 1;
    src1a = 3; #1 checks++;
    if (src1a_mapped !== 1'b0) begin
      errors++; $display("FAIL post_reset got %b want 0", src1a_mapped);
    end
    next();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      disp_en1 = 1'($urandom_range(0, 3) != 0);
      disp_en2 = 1'($urandom_range(0, 3) != 0);
      disp_dest1 = 5'($urandom); disp_dest2 = 5'($urandom);
      disp_tag1 = 5'($urandom); disp_tag2 = 5'($urandom);
      src1a = 5'($urandom); src1b = 5'($urandom);
      src2a = ($urandom_range(0, 2) == 0) ? disp_dest1 : 5'($urandom);
      src2b = 5'($urandom);
      cdb_en1 = 1'($urandom); cdb_en2 = 1'($urandom);
      cdb_tag1 = 5'($urandom); cdb_tag2 = 5'($urandom);
      ret_en = 1'($urandom);
      ret_reg = 5'($urandom);
      ret_tag = ($urandom_range(0, 3) != 0) ? m_tag[ret_reg] : 5'($urandom);
      flush = ($urandom_range(0, 40) == 0);
      #1 checks++;
      if (obs_all() !== exp_all()) begin
        errors++; $display("FAIL random n%0d got %h want %h", n, obs_all(), exp_all());
      end
      next();
    end
  endtask

  initial begin
    test_reset();
    test_dispatch_cdb();
    test_forward();
    test_retire();
    test_flush();
    test_zero_dual_cdb();
    test_reset_midrun();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
